// File: rtl/store_buffer.sv
// Posted-store FIFO between the mem stage and the shared instruction/data memory port.
// Optional macro STORE_FWD_EN: loads hit in the buffer are forwarded; otherwise every load drains the buffer first.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     writeIn,
  input  logic                     readIn,
  input  logic [DATA_W-1:0]        addressIn,
  input  logic [DATA_W-1:0]        dataIn,
  output logic [DATA_W-1:0]        dataOut,
  output logic                     dataValid,
  output logic                     stall,
  output logic [DATA_W-1:0]        memAddr,
  output logic [DATA_W-1:0]        memWData,
  output logic                     memWrite,
  output logic                     memRead,
  input  logic                     memGrant,
  input  logic [DATA_W-1:0]        memRData,
  output logic [1:0]               o_dbg_state,
  output logic [$clog2(DEPTH):0]   o_dbg_count
);

  // Handshake: a mem-stage request (writeIn or readIn) is taken on a rising edge
  // only while stall is 0; memory requests (memWrite/memRead) complete on an edge
  // where memGrant is 1, otherwise they hold their address/data and retry.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = DATA_W - 2;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_REQ  = 2'd1,
    LOAD_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [PTR_W:0]    r_count;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [WA_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [WA_W-1:0]   r_ld_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;

  logic              w_full;
  logic              w_rd;
  logic              w_hit;
  logic              w_miss;
  logic [DATA_W-1:0] w_hit_data;
  logic [WA_W-1:0]   w_word;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_accept;
  logic              w_drain_st;
  logic              w_rd_go;
  logic              w_unused_lsb;

  assign w_word       = addressIn[DATA_W-1:2];
  assign w_unused_lsb = ^addressIn[1:0];
  assign w_full       = (r_count == CNT_FULL);
  // A simultaneous store wins; the load half of such a request is dropped.
  assign w_rd         = readIn && !writeIn;

`ifdef STORE_FWD_EN
  // Scan oldest to youngest so the youngest matching entry is the one kept.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PTR_W+1)'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == w_word)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[r_head + PTR_W'(k)];
      end
    end
  end
  assign w_drain_st = (r_state == IDLE);
  assign w_rd_go    = (r_state == LOAD_REQ);
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
  // Without forwarding the buffer must be empty before memory can be read.
  assign w_drain_st = (r_state == IDLE) || (r_state == LOAD_REQ);
  assign w_rd_go    = (r_state == LOAD_REQ) && (r_count == '0);
`endif

  assign w_miss = !w_hit;

  assign stall = !rst && ((writeIn && w_full) ||
                          ((r_state == IDLE) && w_rd && w_miss) ||
                          (r_state == LOAD_REQ));

  assign memWrite = !rst && w_drain_st && (r_count != '0);
  assign memRead  = !rst && w_rd_go;
  assign memAddr  = memRead ? {r_ld_addr, 2'b00} : {r_addr[r_head], 2'b00};
  assign memWData = r_data[r_head];

  assign w_push      = !rst && writeIn && !w_full;
  assign w_pop       = memWrite && memGrant;
  assign w_ld_accept = w_rd && !stall;

  assign dataOut     = r_dout;
  assign dataValid   = r_dvalid;
  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_ld_addr <= '0;
      r_dout    <= '0;
      r_dvalid  <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;

      if (w_push) begin
        r_addr[r_tail] <= w_word;
        r_data[r_tail] <= dataIn;
        r_tail         <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      case (r_state)
        IDLE: begin
          if (w_rd && w_miss) begin
            r_state   <= LOAD_REQ;
            r_ld_addr <= w_word;
          end else if (w_ld_accept) begin
            r_dout   <= w_hit_data;
            r_dvalid <= 1'b1;
          end
        end
        LOAD_REQ: begin
          if (memRead && memGrant) begin
            r_state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          // Memory data arrives in this cycle; the held load is accepted here.
          r_state  <= IDLE;
          r_dout   <= memRData;
          r_dvalid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain, full/stall, forwarding or drain-before-load, miss, mid-load reset.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int QW    = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         writeIn;
  logic         readIn;
  logic [W-1:0] addressIn;
  logic [W-1:0] dataIn;
  logic [W-1:0] dataOut;
  logic         dataValid;
  logic         stall;
  logic [W-1:0] memAddr;
  logic [W-1:0] memWData;
  logic         memWrite;
  logic         memRead;
  logic         memGrant;
  logic [W-1:0] memRData;
  logic [1:0]   dbg_state;
  logic [2:0]   dbg_count;

  logic [QW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(DEPTH), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .writeIn(writeIn), .readIn(readIn),
    .addressIn(addressIn), .dataIn(dataIn), .dataOut(dataOut), .dataValid(dataValid),
    .stall(stall), .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite),
    .memRead(memRead), .memGrant(memGrant), .memRData(memRData),
    .o_dbg_state(dbg_state), .o_dbg_count(dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every granted drain must match the next expected store in order
  always @(negedge clk) begin
    logic [QW-1:0] exp;
    if (writeIn && readIn) begin
      n_cmp++; n_err++;
      $display("FAIL both_req writeIn and readIn high together");
    end
    if (!rst && (memWrite || memRead)) begin
      n_cmp++;
      if (memWrite && memRead) begin
        n_err++; $display("FAIL port_excl memWrite=%0b memRead=%0b want not both", memWrite, memRead);
      end
    end
    if (!rst && memWrite && memGrant) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL drain_extra addr=%h data=%h want no drain", memAddr, memWData);
      end else begin
        exp = exp_q.pop_front();
        if ({memAddr, memWData} !== exp) begin
          n_err++;
          $display("FAIL drain_order got addr=%h data=%h want addr=%h data=%h",
                   memAddr, memWData, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // driver helpers
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; readIn = 1'b1; addressIn = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%0b want=0", stall); end
    n_cmp++; if (memRead !== 1'b0) begin n_err++; $display("FAIL rst_memRead got=%0b want=0", memRead); end
    n_cmp++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL rst_memWrite got=%0b want=0", memWrite); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
    n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d want=0", dbg_count); end
    n_cmp++; if (dataValid !== 1'b0) begin n_err++; $display("FAIL rst_dataValid got=%0b want=0", dataValid); end
    n_cmp++; if (dataOut !== 32'h0) begin n_err++; $display("FAIL rst_dataOut got=%h want=0", dataOut); end
    next_cycle();
    rst = 1'b0; readIn = 1'b0;
  endtask

  task automatic test_store_drain();
    memGrant = 1'b1; writeIn = 1'b1; addressIn = 32'h100; dataIn = 32'hAAAA0001;
    exp_q.push_back({32'h100, 32'hAAAA0001});
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_stall got=%0b want=0", stall); end
    n_cmp++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL st_early_write got=%0b want=0", memWrite); end
    next_cycle();
    writeIn = 1'b0;
    @(negedge clk);
    n_cmp++; if (memWrite !== 1'b1) begin n_err++; $display("FAIL st_memWrite got=%0b want=1", memWrite); end
    n_cmp++; if (memAddr !== 32'h100) begin n_err++; $display("FAIL st_memAddr got=%h want=100", memAddr); end
    n_cmp++; if (memWData !== 32'hAAAA0001) begin n_err++; $display("FAIL st_memWData got=%h want=aaaa0001", memWData); end
    n_cmp++; if (dbg_count !== 3'd1) begin n_err++; $display("FAIL st_count1 got=%0d want=1", dbg_count); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL st_count0 got=%0d want=0", dbg_count); end
    n_cmp++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL st_idle_write got=%0b want=0", memWrite); end
    next_cycle();
  endtask

  task automatic test_full();
    memGrant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      writeIn = 1'b1; addressIn = 32'(i * 4); dataIn = 32'h1000 + 32'(i);
      exp_q.push_back({addressIn, dataIn});
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fill_stall[%0d] got=%0b want=0", i, stall); end
      next_cycle();
    end
    addressIn = 32'h10; dataIn = 32'h5555;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL full_stall got=%0b want=1", stall); end
    n_cmp++; if (dbg_count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d want=4", dbg_count); end
    n_cmp++; if (memWrite !== 1'b1) begin n_err++; $display("FAIL full_hold_write got=%0b want=1", memWrite); end
    n_cmp++; if (memAddr !== 32'h0) begin n_err++; $display("FAIL full_hold_addr got=%h want=0", memAddr); end
    next_cycle();
    memGrant = 1'b1;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL full_pop_stall got=%0b want=1", stall); end
    next_cycle();
    exp_q.push_back({32'h10, 32'h5555});
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL full_free_stall got=%0b want=0", stall); end
    n_cmp++; if (memAddr !== 32'h4) begin n_err++; $display("FAIL full_second_addr got=%h want=4", memAddr); end
    next_cycle();
    writeIn = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_count !== 3'd3) begin n_err++; $display("FAIL full_pushpop_count got=%0d want=3", dbg_count); end
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL full_empty_count got=%0d want=0", dbg_count); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_left got=%0d want=0", exp_q.size()); end
    next_cycle();
  endtask

`ifdef STORE_FWD_EN
  task automatic test_forward();
    memGrant = 1'b0; writeIn = 1'b1; addressIn = 32'h20; dataIn = 32'h11;
    exp_q.push_back({32'h20, 32'h11});
    next_cycle();
    dataIn = 32'h22;
    exp_q.push_back({32'h20, 32'h22});
    next_cycle();
    writeIn = 1'b0; readIn = 1'b1; addressIn = 32'h20;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_stall got=%0b want=0", stall); end
    n_cmp++; if (memRead !== 1'b0) begin n_err++; $display("FAIL fwd_memRead got=%0b want=0", memRead); end
    n_cmp++; if (dbg_count !== 3'd2) begin n_err++; $display("FAIL fwd_count got=%0d want=2", dbg_count); end
    next_cycle();
    addressIn = 32'h23;
    @(negedge clk);
    n_cmp++; if (dataValid !== 1'b1) begin n_err++; $display("FAIL fwd_valid got=%0b want=1", dataValid); end
    n_cmp++; if (dataOut !== 32'h22) begin n_err++; $display("FAIL fwd_data got=%h want=22", dataOut); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_off_stall got=%0b want=0", stall); end
    next_cycle();
    readIn = 1'b0; addressIn = 32'h24;
    @(negedge clk);
    n_cmp++; if (dataValid !== 1'b1) begin n_err++; $display("FAIL fwd_off_valid got=%0b want=1", dataValid); end
    n_cmp++; if (dataOut !== 32'h22) begin n_err++; $display("FAIL fwd_off_data got=%h want=22", dataOut); end
    next_cycle();
    memGrant = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL fwd_drained got=%0d want=0", dbg_count); end
    next_cycle();
    memGrant = 1'b0;
  endtask
`else
  task automatic test_no_fwd();
    memGrant = 1'b0; writeIn = 1'b1; addressIn = 32'h80; dataIn = 32'h111;
    exp_q.push_back({32'h80, 32'h111});
    next_cycle();
    addressIn = 32'h84; dataIn = 32'h222;
    exp_q.push_back({32'h84, 32'h222});
    next_cycle();
    writeIn = 1'b0; readIn = 1'b1; addressIn = 32'h80;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL nf_stall got=%0b want=1", stall); end
    n_cmp++; if (memRead !== 1'b0) begin n_err++; $display("FAIL nf_idle_read got=%0b want=0", memRead); end
    next_cycle();
    memGrant = 1'b1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL nf_state_req got=%0d want=1", dbg_state); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL nf_req_stall got=%0b want=1", stall); end
    n_cmp++; if (memRead !== 1'b0) begin n_err++; $display("FAIL nf_req_read0 got=%0b want=0", memRead); end
    n_cmp++; if (memAddr !== 32'h80) begin n_err++; $display("FAIL nf_drain0_addr got=%h want=80", memAddr); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (memAddr !== 32'h84) begin n_err++; $display("FAIL nf_drain1_addr got=%h want=84", memAddr); end
    n_cmp++; if (memRead !== 1'b0) begin n_err++; $display("FAIL nf_req_read1 got=%0b want=0", memRead); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (memRead !== 1'b1) begin n_err++; $display("FAIL nf_read got=%0b want=1", memRead); end
    n_cmp++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL nf_read_write got=%0b want=0", memWrite); end
    n_cmp++; if (memAddr !== 32'h80) begin n_err++; $display("FAIL nf_read_addr got=%h want=80", memAddr); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL nf_left got=%0d want=0", exp_q.size()); end
    next_cycle();
    memRData = 32'h111;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL nf_state_wait got=%0d want=2", dbg_state); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nf_wait_stall got=%0b want=0", stall); end
    next_cycle();
    readIn = 1'b0; memRData = 32'h0; memGrant = 1'b0;
    @(negedge clk);
    n_cmp++; if (dataValid !== 1'b1) begin n_err++; $display("FAIL nf_valid got=%0b want=1", dataValid); end
    n_cmp++; if (dataOut !== 32'h111) begin n_err++; $display("FAIL nf_data got=%h want=111", dataOut); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL nf_state_idle got=%0d want=0", dbg_state); end
    next_cycle();
  endtask
`endif

  task automatic test_miss();
    memGrant = 1'b0; readIn = 1'b1; addressIn = 32'h40;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL miss_stall got=%0b want=1", stall); end
    n_cmp++; if (memRead !== 1'b0) begin n_err++; $display("FAIL miss_read_idle got=%0b want=0", memRead); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL miss_state[%0d] got=%0d want=1", i, dbg_state); end
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL miss_req_stall[%0d] got=%0b want=1", i, stall); end
      n_cmp++; if (memRead !== 1'b1) begin n_err++; $display("FAIL miss_read[%0d] got=%0b want=1", i, memRead); end
      n_cmp++; if (memAddr !== 32'h40) begin n_err++; $display("FAIL miss_addr[%0d] got=%h want=40", i, memAddr); end
    end
    next_cycle();
    memGrant = 1'b1;
    @(negedge clk);
    n_cmp++; if (memRead !== 1'b1) begin n_err++; $display("FAIL miss_grant_read got=%0b want=1", memRead); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL miss_grant_stall got=%0b want=1", stall); end
    next_cycle();
    memGrant = 1'b0; memRData = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL miss_state_wait got=%0d want=2", dbg_state); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL miss_wait_stall got=%0b want=0", stall); end
    n_cmp++; if (dataValid !== 1'b0) begin n_err++; $display("FAIL miss_early_valid got=%0b want=0", dataValid); end
    next_cycle();
    readIn = 1'b0; memRData = 32'h0;
    @(negedge clk);
    n_cmp++; if (dataValid !== 1'b1) begin n_err++; $display("FAIL miss_valid got=%0b want=1", dataValid); end
    n_cmp++; if (dataOut !== 32'hDEADBEEF) begin n_err++; $display("FAIL miss_data got=%h want=deadbeef", dataOut); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL miss_state_idle got=%0d want=0", dbg_state); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (dataValid !== 1'b0) begin n_err++; $display("FAIL miss_pulse got=%0b want=0", dataValid); end
    n_cmp++; if (dataOut !== 32'hDEADBEEF) begin n_err++; $display("FAIL miss_hold got=%h want=deadbeef", dataOut); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    memGrant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      writeIn = 1'b1; addressIn = 32'h200 + 32'(i * 4); dataIn = 32'h300 + 32'(i);
      next_cycle();
    end
    writeIn = 1'b0; readIn = 1'b1; addressIn = 32'h300;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rm_stall got=%0b want=1", stall); end
    next_cycle();
`ifdef STORE_FWD_EN
    memGrant = 1'b1;
    @(negedge clk);
    n_cmp++; if (memRead !== 1'b1) begin n_err++; $display("FAIL rm_read got=%0b want=1", memRead); end
    next_cycle();
    memGrant = 1'b0; memRData = 32'h0BAD0BAD; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL rm_state_wait got=%0d want=2", dbg_state); end
`else
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rm_state_req got=%0d want=1", dbg_state); end
`endif
    n_cmp++; if (dbg_count !== 3'd3) begin n_err++; $display("FAIL rm_count3 got=%0d want=3", dbg_count); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_rst_stall got=%0b want=0", stall); end
    next_cycle();
    rst = 1'b0; readIn = 1'b0; memRData = 32'h0;
    @(negedge clk);
    n_cmp++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL rm_count got=%0d want=0", dbg_count); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rm_state got=%0d want=0", dbg_state); end
    n_cmp++; if (memWrite !== 1'b0) begin n_err++; $display("FAIL rm_memWrite got=%0b want=0", memWrite); end
    n_cmp++; if (dataValid !== 1'b0) begin n_err++; $display("FAIL rm_dataValid got=%0b want=0", dataValid); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_stall_after got=%0b want=0", stall); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; writeIn = 1'b0; readIn = 1'b0; addressIn = '0; dataIn = '0;
    memGrant = 1'b0; memRData = '0;
    test_reset();
    test_store_drain();
    test_full();
`ifdef STORE_FWD_EN
    test_forward();
`else
    test_no_fwd();
`endif
    test_miss();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the mem stage and the unified instruction_and_data memory.
- Takes the mem stage's write requests into a small FIFO of posted stores. Drains them to the shared memory port on cycles when instruction fetch does not hold the port.
- Serves loads from the youngest matching buffered store, or from memory on a miss.
- Asserts stall back to the pipeline when the buffer is full or a load miss is outstanding.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16
- DATA_W, 32, data and address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- writeIn  in  1  store request from mem stage
- readIn  in  1  load request from mem stage
- addressIn  in  32  byte address; bits [1:0] ignored, word stores only
- dataIn  in  32  store data
- dataOut  out  32  load data, registered
- dataValid  out  1  one-cycle pulse; dataOut holds load result
- stall  out  1  pipeline must hold the mem-stage request
- memAddr  out  32  address to instruction_and_data
- memWData  out  32  write data to memory
- memWrite  out  1  drain-write request
- memRead  out  1  load-read request
- memGrant  in  1  memory port available this cycle; fetch has priority
- memRData  in  32  read data, valid the cycle after memRead&&memGrant

Behaviour:
- Reset (rst high at an edge): count=0, head=tail=0, state=IDLE, dataOut=0, dataValid=0. Buffered stores and an in-flight load are discarded. While rst is high, memWrite, memRead and stall are 0.
- FSM states:
  - IDLE -> LOAD_REQ on a load miss.
  - LOAD_REQ -> LOAD_WAIT on memRead&&memGrant.
  - LOAD_WAIT -> IDLE unconditionally.
- A load is accepted in a cycle where readIn=1 and stall=0. dataValid=1 and dataOut are driven the following cycle. A hit therefore has latency 1.
- Stall equation: stall = (writeIn && count==DEPTH) || (state==IDLE && readIn && miss) || state==LOAD_REQ.
  - stall is 0 in LOAD_WAIT. That cycle accepts the held load.
  - readIn in LOAD_WAIT does not re-trigger a miss.
- Store accept: writeIn && count<DEPTH. Entry {addressIn[31:2], dataIn} is written at tail; tail advances, wrapping mod DEPTH.
- Full is checked against the registered count. A pop in the same cycle does not free space for a store that cycle.
- Drain: in IDLE with count>0, memWrite=1, memAddr={head addr,2'b00}, memWData=head data.
  - Pop occurs when memWrite&&memGrant.
  - If memGrant=0, outputs hold and retry the next cycle.
- Push and pop in the same cycle leave count unchanged. Ordering is strictly FIFO.
- Hit: word-address compare against all valid entries; the youngest matching entry wins. dataOut <= that entry's data.
- Miss: FSM enters LOAD_REQ with the address latched. memRead=1 and memAddr=latched address until memGrant. No drain occurs in LOAD_REQ or LOAD_WAIT.
- In LOAD_WAIT: dataOut <= memRData; dataValid=1 next cycle.
- writeIn and readIn are never asserted together by the mem stage. If both are high, the store is taken and the load is ignored; the bench flags this as an error.
- memWrite and memRead are never both 1.

Optional Feature:
- Macro: STORE_FWD_EN
- Defined: buffer hits forward as described above. LOAD_REQ issues memRead immediately; a miss cannot alias a buffered store.
- Undefined:
  - No address compare; every load with count>0, or any load at all, takes the miss path.
  - LOAD_REQ keeps draining (memWrite as in IDLE) until count==0, and only then drives memRead.
  - Stall is held throughout LOAD_REQ.

Test Plan:
- Store 0x100<=0xAAAA0001 with memGrant=1 -> next cycle memWrite=1, memAddr=0x100, memWData=0xAAAA0001; count returns to 0 after the grant.
- memGrant=0; four stores to 0x0,0x4,0x8,0xC, then a fifth store -> stall=1 on the fifth. Release grant -> drains in order 0x0..0xC. The fifth store is accepted the cycle after the first pop.
- Buffered stores 0x20<=0x11 then 0x20<=0x22; load 0x20 (FWD_EN) -> stall=0, next cycle dataValid=1, dataOut=0x22, no memRead.
- Load 0x40 miss, memGrant low for 3 cycles -> stall=1 for the miss cycle plus LOAD_REQ. memRead at grant; memRData=0xDEADBEEF -> dataValid=1, dataOut=0xDEADBEEF one cycle after LOAD_WAIT.
- Without FWD_EN: 2 stores buffered, then load 0x80 -> both drain before memRead asserts. The load returns memory data, and store order is preserved.
- rst asserted during LOAD_WAIT with 3 stores buffered -> next cycle count=0, state IDLE, memWrite=0, dataValid=0, stall=0.
